// File: rtl/snes_poller.sv
// SNES gamepad poller: periodically latches the controller, clocks out 16 serial bits
// and presents them as an active-high button vector with a one-cycle valid strobe.
module snes_poller #(
  parameter int HALF_PERIOD = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_serial_data,
  input  logic        i_poll_now,
  output logic        o_snes_clk,
  output logic        o_data_latch,
  output logic [15:0] o_buttons,
  output logic        o_buttons_valid,
  output logic        o_busy
);

  localparam int PH_W = $clog2(2 * HALF_PERIOD);
  localparam int PC_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [PH_W-1:0] PH_HALF_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] PH_FULL_LAST = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [PC_W-1:0] PC_LAST      = PC_W'(POLL_PERIOD - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LATCH    = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_CLK_LOW  = 3'd3;
  localparam logic [2:0] ST_CLK_HIGH = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  logic [1:0]      r_sync;
  logic [2:0]      r_state;
  logic [PH_W-1:0] r_phase;
  logic [PC_W-1:0] r_poll_cnt;
  logic [3:0]      r_bit;
  logic [15:0]     r_shift;
  logic [15:0]     r_buttons;

  logic w_phase_end;
  logic w_poll_go;
  logic w_timed;

  always_comb begin
    w_phase_end = (r_state == ST_LATCH) ? (r_phase == PH_FULL_LAST)
                                        : (r_phase == PH_HALF_LAST);
    w_poll_go   = (r_state == ST_IDLE) && (i_poll_now || (r_poll_cnt == PC_LAST));
    w_timed     = (r_state == ST_LATCH) || (r_state == ST_GAP) ||
                  (r_state == ST_CLK_LOW) || (r_state == ST_CLK_HIGH);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync     <= 2'b11;
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_poll_cnt <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_buttons  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_serial_data};

      if (w_timed) begin
        r_phase <= w_phase_end ? '0 : r_phase + PH_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_poll_go) begin
            r_state    <= ST_LATCH;
            r_poll_cnt <= '0;
          end else begin
            r_poll_cnt <= r_poll_cnt + PC_W'(1);
          end
        end
        ST_LATCH: begin
          if (w_phase_end) r_state <= ST_GAP;
        end
        ST_GAP: begin
          r_bit <= '0;
          if (w_phase_end) r_state <= ST_CLK_LOW;
        end
        ST_CLK_LOW: begin
          if (w_phase_end) begin
            r_shift[r_bit] <= r_sync[1];
            r_state        <= ST_CLK_HIGH;
          end
        end
        ST_CLK_HIGH: begin
          if (w_phase_end) begin
            if (r_bit == 4'd15) begin
              // Load here so the new word is already visible during the DONE strobe.
              r_buttons <= ~r_shift;
              r_state   <= ST_DONE;
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_state <= ST_CLK_LOW;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_snes_clk      = (r_state != ST_CLK_LOW);
    o_data_latch    = (r_state == ST_LATCH);
    o_busy          = (r_state != ST_IDLE);
    o_buttons_valid = (r_state == ST_DONE);
    o_buttons       = r_buttons;
  end

endmodule
